// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: loader FSM states, byte width
// and instruction-store depth.
package loader_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned IMEM_DEPTH = 256;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_HI    = 3'd2,
        S_LO    = 3'd3,
        S_WRITE = 3'd4,
        S_CSUM  = 3'd5,
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } state_e;

endpackage

// File: rtl/prog_loader.sv
// prog_loader: byte-stream loader that writes 16-bit instruction words into
// the CPU instruction store, holding the CPU in reset during the load and
// releasing it only when the trailing XOR checksum matches.
//
// Ports:
//   clk, rst          system clock (rising edge), async active-high reset
//   start             begin a session (honoured in IDLE/DONE/ERR only)
//   in_valid/in_data  byte stream; a byte moves when in_valid && in_ready
//   in_ready          loader accepts a byte this cycle
//   imem_wr_en        one-cycle write strobe per word
//   imem_addr         word index being written
//   imem_wr_data      word being written
//   cpu_rst           holds the CPU in reset while high
//   busy              session in progress (LEN..CSUM)
//   done              one-cycle pulse on a good checksum
//   err               sticky checksum-mismatch flag
module prog_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_wr_en,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wr_data,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // One extra bit so a full-store count (256) is representable.
    localparam int unsigned CNT_W = ADDR_W + 1;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic [BYTE_W-1:0]   hi_q, hi_d;
    logic [BYTE_W-1:0]   xor_q, xor_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic                in_ready_q, in_ready_d;
    logic                wr_en_q, wr_en_d;
    logic                cpu_rst_q, cpu_rst_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                xfer;
    logic [CNT_W-1:0]    cnt_inc;

    assign xfer    = in_valid && in_ready_q;
    assign cnt_inc = cnt_q + CNT_W'(1);

    // State register and datapath/output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            hi_q       <= '0;
            xor_q      <= '0;
            word_q     <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            cpu_rst_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            hi_q       <= hi_d;
            xor_q      <= xor_d;
            word_q     <= word_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            cpu_rst_q  <= cpu_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        hi_d    = hi_q;
        xor_d   = xor_q;
        word_d  = word_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN;
                    cnt_d   = '0;
                    xor_d   = '0;
                end
            end
            S_LEN: begin
                if (xfer) begin
                    // A zero length byte encodes a full store.
                    len_d   = (in_data == 8'd0) ? CNT_W'(IMEM_DEPTH) : CNT_W'(in_data);
                    state_d = S_HI;
                end
            end
            S_HI: begin
                if (xfer) begin
                    hi_d    = in_data;
                    xor_d   = xor_q ^ in_data;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (xfer) begin
                    word_d  = DATA_W'({hi_q, in_data});
                    xor_d   = xor_q ^ in_data;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                cnt_d   = cnt_inc;
                state_d = (cnt_inc == len_q) ? S_CSUM : S_HI;
            end
            S_CSUM: begin
                if (xfer) begin
                    state_d = (in_data == xor_q) ? S_DONE : S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are valid as registers
    // in the same cycle the state register holds that state.
    always_comb begin
        in_ready_d = 1'b0;
        busy_d     = 1'b0;
        wr_en_d    = 1'b0;
        cpu_rst_d  = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;

        in_ready_d = (state_d == S_LEN) || (state_d == S_HI) ||
                     (state_d == S_LO)  || (state_d == S_CSUM);
        busy_d     = in_ready_d || (state_d == S_WRITE);
        wr_en_d    = (state_d == S_WRITE);
        // CPU stays held after a bad checksum so a corrupt image never runs.
        cpu_rst_d  = busy_d || (state_d == S_ERR);
        done_d     = (state_d == S_DONE) && (state_q != S_DONE);
        err_d      = (state_d == S_ERR);
    end

    assign in_ready     = in_ready_q;
    assign imem_wr_en   = wr_en_q;
    assign imem_addr    = cnt_q[ADDR_W-1:0];
    assign imem_wr_data = word_q;
    assign cpu_rst      = cpu_rst_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames with a write
// scoreboard (expected {addr,data} queued as bytes are sent, popped on
// every imem_wr_en).
module tb_prog_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_wr_en;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wr_data;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    prog_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_wr_en   (imem_wr_en),
        .imem_addr    (imem_addr),
        .imem_wr_data (imem_wr_data),
        .cpu_rst      (cpu_rst),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          done_pulses = 0;
    int          rst_low_cycles = 0;
    bit          in_session = 0;
    logic [23:0] exp_q[$];
    logic [15:0] words[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample outputs 1ns after the edge.
    task automatic tick();
        logic [23:0] e;
        @(posedge clk);
        #1;
        if (done) done_pulses++;
        if (in_session && !cpu_rst && !done) rst_low_cycles++;
        if (imem_wr_en) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_write addr=0x%0h data=0x%0h", imem_addr, imem_wr_data);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(imem_addr), 32'(e[23:16]));
                check("wr_data", 32'(imem_wr_data), 32'(e[15:0]));
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit with_start);
        bit got;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                tick();
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        start    = with_start;
        got      = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            got = in_ready;
            tick();
            start = 1'b0;
        end
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        checks++;
        assert (got) else begin
            failures++;
            $error("FAIL byte_accept_timeout observed=not_accepted expected=accepted byte=0x%0h", b);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_cpu_rst", 32'(cpu_rst), 32'd1);
        check("start_busy", 32'(busy), 32'd1);
        check("start_in_ready", 32'(in_ready), 32'd1);
        check("start_err_clear", 32'(err), 32'd0);
    endtask

    // Full session from start to checksum over the current words queue.
    task automatic run_frame(input int nw, input bit bad, input bit gaps, input bit poke);
        logic [7:0] cs;
        int         base;
        cs = 8'h00;
        do_start();
        in_session     = 1;
        rst_low_cycles = 0;
        base           = done_pulses;
        send_byte(8'(nw), gaps, 1'b0);
        for (int i = 0; i < nw; i++) begin
            cs = cs ^ words[i][15:8] ^ words[i][7:0];
            send_byte(words[i][15:8], gaps, poke && (i == 0));
            exp_q.push_back({8'(i), words[i]});
            send_byte(words[i][7:0], gaps, 1'b0);
            check("wr_latency", 32'(imem_wr_en), 32'd1);
        end
        send_byte(bad ? (cs ^ 8'h01) : cs, gaps, 1'b0);
        check("end_done", 32'(done), bad ? 32'd0 : 32'd1);
        check("end_err", 32'(err), bad ? 32'd1 : 32'd0);
        check("end_cpu_rst", 32'(cpu_rst), bad ? 32'd1 : 32'd0);
        check("end_busy", 32'(busy), 32'd0);
        in_session = 0;
        tick();
        tick();
        check("after_done_low", 32'(done), 32'd0);
        check("after_err_sticky", 32'(err), bad ? 32'd1 : 32'd0);
        check("after_cpu_rst", 32'(cpu_rst), bad ? 32'd1 : 32'd0);
        check("after_in_ready", 32'(in_ready), 32'd0);
        check("done_pulse_count", 32'(done_pulses - base), bad ? 32'd0 : 32'd1);
        check("cpu_rst_held", 32'(rst_low_cycles), 32'd0);
        check("writes_all_seen", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_wr_en"}, 32'(imem_wr_en), 32'd0);
        check({tag, "_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "_wr_data"}, 32'(imem_wr_data), 32'd0);
        check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();
        check_reset_outputs("idle");

        // Normal two-word frame.
        words = '{16'h1234, 16'hABCD};
        run_frame(2, 1'b0, 1'b0, 1'b0);

        // Same frame with a corrupted checksum.
        run_frame(2, 1'b1, 1'b0, 1'b0);

        // Gaps in in_valid; the start inside run_frame also clears err.
        run_frame(2, 1'b0, 1'b1, 1'b0);
        run_frame(2, 1'b0, 1'b1, 1'b0);

        // start pulsed during HI must be ignored.
        words = '{16'hBEEF, 16'h0F0F, 16'h5AA5};
        run_frame(3, 1'b0, 1'b0, 1'b1);

        // Full 256-word store.
        words.delete();
        for (int i = 0; i < 256; i++) words.push_back(16'($urandom));
        run_frame(256, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a 4-word frame.
        words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        do_start();
        send_byte(8'd4, 1'b0, 1'b0);
        send_byte(words[0][15:8], 1'b0, 1'b0);
        exp_q.push_back({8'd0, words[0]});
        send_byte(words[0][7:0], 1'b0, 1'b0);
        send_byte(words[1][15:8], 1'b0, 1'b0);
        check("mid_busy_before_rst", 32'(busy), 32'd1);
        check("mid_first_word_written", 32'(exp_q.size()), 32'd0);
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_no_write", 32'(imem_wr_en), 32'd0);
        end
        rst = 1'b0;
        tick();
        check_reset_outputs("post_rst_idle");
        run_frame(4, 1'b0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader that writes 16-bit instruction words into the CPU's 256-entry instruction storage. It is the write side of the instruction store, which the CPU core only reads. The loader holds the CPU in reset while loading and checks a trailing XOR checksum. On success it releases the CPU so that execution restarts at PC 0 with the new program.

## Interface

Parameters:
- ADDR_W, 8, instruction-store address width (256 words).
- DATA_W, 16, instruction word width; must equal 2 bytes.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a load session; sampled in IDLE, DONE or ERR only.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  loader can accept a byte this cycle.
- imem_wr_en  output  1  instruction-store write strobe, one cycle per word.
- imem_addr  output  ADDR_W  write address (word index).
- imem_wr_data  output  DATA_W  word to write.
- cpu_rst  output  1  hold CPU (PC/ACC) in reset while high.
- busy  output  1  session in progress (LEN through CSUM).
- done  output  1  one-cycle pulse on successful completion.
- err  output  1  sticky checksum-mismatch flag, cleared by next start or rst.

## Operation

- Frame format: one length byte N, then 2·N data bytes (high byte first per word), then one checksum byte.
  - N=0 means 256 words.
  - Checksum = XOR of all 2·N data bytes. The length byte is excluded.
- A byte transfers when in_valid && in_ready. There is no other flow control. in_data is ignored when no transfer occurs.
- FSM states: IDLE, LEN, HI, LO, WRITE, CSUM, DONE, ERR.
  - IDLE/DONE/ERR --start--> LEN. On this transition: clear err, clear the word counter, clear the XOR accumulator, and assert cpu_rst.
  - LEN --byte--> HI. Latch N (0 maps to 256, held in a 9-bit count).
  - HI --byte--> LO. Latch the high byte and fold it into the XOR.
  - LO --byte--> WRITE. Form the word and fold the low byte into the XOR.
  - WRITE: pulse imem_wr_en and increment the word counter. Go to CSUM if the incremented count equals N, else go to HI.
  - CSUM --byte--> DONE if the byte equals the accumulator, else ERR.
  - DONE: done pulses in the entry cycle only. cpu_rst is low. The FSM stays in DONE.
  - ERR: err=1 and cpu_rst stays high, so the CPU never runs a corrupt program. The FSM stays in ERR.
- start is ignored while busy.
- Reset in the middle of a session returns to IDLE. Words already written stay in the store. No further writes occur.
- imem_addr = word counter[ADDR_W-1:0]. It wraps from 255 to 0 only after the final word of a 256-word load, and that wrapped value is never written.

## Timing

- Reset values:
  - state=IDLE
  - in_ready=0, imem_wr_en=0, imem_addr=0, imem_wr_data=0
  - cpu_rst=0, busy=0, done=0, err=0
- in_ready=1 exactly in LEN, HI, LO and CSUM. in_ready is a registered-state decode with no combinational path from in_valid.
- busy=1 in LEN, HI, LO, WRITE and CSUM.
- Write latency: the imem_wr_en pulse occurs in the cycle after the LO byte transfer, with imem_addr and imem_wr_data stable in that cycle. The instruction store captures the write on the following clock edge.
- Peak throughput: 1 word per 3 cycles (HI, LO, WRITE).
- done rises in the cycle after the CSUM transfer. cpu_rst falls in that same cycle.
- cpu_rst rises in the cycle after start is sampled.
- Minimum session length: 1 + 3·N + 1 cycles of accepted bytes/writes after LEN entry.

## Structure

- Shared package loader_pkg:
  - state enum (8 states, 3-bit encoding).
  - constant for byte width 8.
  - constant IMEM_DEPTH = 256.
- A single module is sufficient. An optional sub-module byte_pack_16b (HI/LO byte assembly) is acceptable. No other hierarchy.

## Test plan

- Normal load: start, then bytes 0x02, 0x12, 0x34, 0xAB, 0xCD, 0x40. Required response:
  - writes (addr 0, 0x1234) and (addr 1, 0xABCD).
  - done pulses once; cpu_rst high from start until done; err=0.
- Bad checksum: same frame with a final byte of 0x41. Required response: both words are written, done stays 0, err=1 and cpu_rst stays 1. A following start clears err.
- Backpressure/gaps: same frame with in_valid dropped for random cycles, including during WRITE. Required response: an identical write sequence, and no byte is lost or duplicated while in_ready=0.
- Full store: N=0x00 followed by 512 bytes. Required response: 256 writes at addr 0..255 in order, then CSUM, then done.
- Reset mid-load: assert rst after the first word has been written in a 4-word frame. Required response: all outputs return to reset values asynchronously, with no further imem_wr_en. A new start then loads correctly.
- start while busy: pulse start during HI. Required response: it is ignored, and the counter and XOR are undisturbed.
